// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_frame_sequencer: ping-pong ADC frame buffer feeding a streaming FFT  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fft_frame_sequencer #(
  parameter int FFT_LENGTH = 1024,
  parameter int SAMPLE_W   = 12
) (
  input  logic                          MAX10_CLK1_50,
  input  logic                          reset,
  input  logic                          start,
  input  logic [SAMPLE_W-1:0]           adc_data,
  input  logic                          adc_data_valid,
  output logic                          ram_wr_en,
  output logic [$clog2(FFT_LENGTH):0]   ram_wr_addr,
  output logic [SAMPLE_W-1:0]           ram_wr_data,
  output logic [$clog2(FFT_LENGTH):0]   ram_rd_addr,
  input  logic [SAMPLE_W-1:0]           ram_rd_data,
  output logic                          fft_sink_valid,
  output logic                          fft_sink_sop,
  output logic                          fft_sink_eop,
  output logic [SAMPLE_W-1:0]           fft_sink_real,
  input  logic                          fft_sink_ready,
  input  logic                          fft_done,
  output logic [3:0]                    frame_id,
  output logic                          overflow,
  output logic                          busy
);

  localparam int AW = $clog2(FFT_LENGTH);
  localparam int EW = SAMPLE_W + 2;
  localparam logic [AW-1:0] c_LAST_IDX = AW'(FFT_LENGTH - 1);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_STREAM    = 2'd1;
  localparam logic [1:0] c_WAIT_DONE = 2'd2;

  logic          fill_bank_q, fill_bank_d;
  logic [AW-1:0] fill_idx_q, fill_idx_d;
  logic [1:0]    full_q, full_d;
  logic          overflow_q, overflow_d;

  logic [1:0]    state_q, state_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW:0]   rd_cnt_q, rd_cnt_d;
  logic [3:0]    frame_id_q, frame_id_d;
  logic          infl_q, infl_d;
  logic          infl_sop_q, infl_sop_d;
  logic          infl_eop_q, infl_eop_d;
  logic [EW-1:0] skid_q [0:1];
  logic [EW-1:0] skid_d [0:1];
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic [1:0]    cnt_q, cnt_d;

  logic          strobe;
  logic          fill_free;
  logic          wr;
  logic          release_bank;
  logic [EW-1:0] head;
  logic          out_valid;
  logic          pop;
  logic [1:0]    occ;
  logic          issue;

  // A bank being released this cycle counts as free, so no sample is lost.
  assign strobe    = start && adc_data_valid && !reset;
  assign fill_free = !full_q[fill_bank_q] || (release_bank && (rd_bank_q == fill_bank_q));
  assign wr        = strobe && fill_free;

  always_comb begin
    fill_bank_d = fill_bank_q;
    fill_idx_d  = fill_idx_q;
    full_d      = full_q;
    overflow_d  = overflow_q;
    if (release_bank) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (wr) begin
      if (fill_idx_q == c_LAST_IDX) begin
        full_d[fill_bank_q] = 1'b1;
        fill_idx_d          = '0;
        fill_bank_d         = ~fill_bank_q;
      end else begin
        fill_idx_d = fill_idx_q + AW'(1);
      end
    end
    if (strobe && !fill_free) begin
      overflow_d = 1'b1;
    end
  end

  // Slots are reserved for the in-flight read so the skid buffer never overruns.
  assign head         = skid_q[rptr_q];
  assign out_valid    = (cnt_q != 2'd0);
  assign pop          = out_valid && fft_sink_ready;
  assign release_bank = pop && head[SAMPLE_W] && (state_q == c_STREAM);
  assign occ          = cnt_q + {1'b0, infl_q} - {1'b0, pop};
  assign issue        = (state_q == c_STREAM) && !rd_cnt_q[AW] && !occ[1];

  always_comb begin
    state_d    = state_q;
    rd_bank_d  = rd_bank_q;
    rd_cnt_d   = rd_cnt_q;
    frame_id_d = frame_id_q;
    infl_d     = issue;
    infl_sop_d = issue && (rd_cnt_q == '0);
    infl_eop_d = issue && (rd_cnt_q[AW-1:0] == c_LAST_IDX);
    skid_d     = skid_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = occ;
    if (infl_q) begin
      skid_d[wptr_q] = {infl_sop_q, infl_eop_q, ram_rd_data};
      wptr_d         = ~wptr_q;
    end
    if (pop) begin
      rptr_d = ~rptr_q;
    end
    if (issue) begin
      rd_cnt_d = rd_cnt_q + (AW + 1)'(1);
    end
    case (state_q)
      c_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d  = c_STREAM;
          rd_cnt_d = '0;
        end
      end
      c_STREAM: begin
        if (release_bank) begin
          state_d    = c_WAIT_DONE;
          rd_bank_d  = ~rd_bank_q;
          frame_id_d = frame_id_q + 4'd1;
        end
      end
      c_WAIT_DONE: begin
        if (fft_done) begin
          state_d = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      fill_bank_q <= 1'b0;
      fill_idx_q  <= '0;
      full_q      <= 2'b00;
      overflow_q  <= 1'b0;
      state_q     <= c_IDLE;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      frame_id_q  <= 4'd0;
      infl_q      <= 1'b0;
      infl_sop_q  <= 1'b0;
      infl_eop_q  <= 1'b0;
      skid_q[0]   <= '0;
      skid_q[1]   <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      fill_bank_q <= fill_bank_d;
      fill_idx_q  <= fill_idx_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      frame_id_q  <= frame_id_d;
      infl_q      <= infl_d;
      infl_sop_q  <= infl_sop_d;
      infl_eop_q  <= infl_eop_d;
      skid_q      <= skid_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ram_wr_en      = wr;
  assign ram_wr_addr    = {fill_bank_q, fill_idx_q};
  assign ram_wr_data    = wr ? adc_data : '0;
  assign ram_rd_addr    = {rd_bank_q, rd_cnt_q[AW-1:0]};
  assign fft_sink_valid = out_valid;
  assign fft_sink_sop   = out_valid && head[SAMPLE_W+1];
  assign fft_sink_eop   = out_valid && head[SAMPLE_W];
  assign fft_sink_real  = out_valid ? head[SAMPLE_W-1:0] : '0;
  assign frame_id       = frame_id_q;
  assign overflow       = overflow_q;
  assign busy           = (state_q != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fft_frame_sequencer: directed bench with ping-pong RAM model          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fft_frame_sequencer;
  localparam int N = 1024;
  localparam int W = 12;

  logic          clk = 1'b0;
  logic          reset, start, adc_data_valid, fft_sink_ready, fft_done;
  logic [W-1:0]  adc_data;
  logic          ram_wr_en;
  logic [10:0]   ram_wr_addr, ram_rd_addr;
  logic [W-1:0]  ram_wr_data, ram_rd_data;
  logic          fft_sink_valid, fft_sink_sop, fft_sink_eop;
  logic [W-1:0]  fft_sink_real;
  logic [3:0]    frame_id;
  logic          overflow, busy;

  logic [W-1:0]  mem [0:2*N-1];
  logic [13:0]   beats [$];
  logic [W-1:0]  exp_q [$];
  int            checks = 0;
  int            failures = 0;
  int            ncyc = 0;
  int            wr_cnt = 0;
  int            proto_err = 0;
  int            sop_cyc = 0;
  int            eop_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [13:0]   prev_beat = '0;
  logic          rdy_rand = 1'b0;
  logic          auto_done = 1'b0;
  logic [3:0]    last_fid = 4'd0;

  fft_frame_sequencer #(.FFT_LENGTH(N), .SAMPLE_W(W)) dut (
    .MAX10_CLK1_50 (clk),
    .reset         (reset),
    .start         (start),
    .adc_data      (adc_data),
    .adc_data_valid(adc_data_valid),
    .ram_wr_en     (ram_wr_en),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_data   (ram_wr_data),
    .ram_rd_addr   (ram_rd_addr),
    .ram_rd_data   (ram_rd_data),
    .fft_sink_valid(fft_sink_valid),
    .fft_sink_sop  (fft_sink_sop),
    .fft_sink_eop  (fft_sink_eop),
    .fft_sink_real (fft_sink_real),
    .fft_sink_ready(fft_sink_ready),
    .fft_done      (fft_done),
    .frame_id      (frame_id),
    .overflow      (overflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data one cycle after the address.
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  // Beat capture and stall-stability monitor.
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (ram_wr_en) wr_cnt <= wr_cnt + 1;
    if (fft_sink_valid && fft_sink_ready) begin
      beats.push_back({fft_sink_sop, fft_sink_eop, fft_sink_real});
      if (fft_sink_sop) sop_cyc <= ncyc;
      if (fft_sink_eop) eop_cyc <= ncyc;
    end
    if (prev_stall && (!fft_sink_valid || ({fft_sink_sop, fft_sink_eop, fft_sink_real} != prev_beat)))
      proto_err <= proto_err + 1;
    prev_stall <= fft_sink_valid && !fft_sink_ready && !reset;
    prev_beat  <= {fft_sink_sop, fft_sink_eop, fft_sink_real};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    fft_done = 1'b0;
    if (auto_done && (frame_id != last_fid)) fft_done = 1'b1;
    last_fid = frame_id;
    if (rdy_rand) fft_sink_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic feed(input int first, input int n, input int base);
    for (int k = first; k < first + n; k++) begin
      adc_data_valid = 1'b1;
      adc_data = W'((base + k) & 'hFFF);
      exp_q.push_back(W'((base + k) & 'hFFF));
      cyc();
    end
    adc_data_valid = 1'b0;
  endtask

  task automatic wait_fid(input logic [3:0] tgt, input int budget, input string tag);
    int k = 0;
    while ((frame_id !== tgt) && (k < budget)) begin
      cyc();
      k++;
    end
    check(tag, 32'(frame_id), 32'(tgt));
  endtask

  task automatic cmp_stream(input string tag, input int bs, input int es, input int n);
    int errs = 0;
    check({tag, " beat count"}, beats.size() - bs, n);
    for (int k = 0; k < n; k++) begin
      logic [13:0] eb;
      eb = {(k % N) == 0, (k % N) == (N - 1), exp_q[es + k]};
      if ((bs + k >= beats.size()) || (beats[bs + k] !== eb)) errs++;
    end
    check({tag, " beat content"}, errs, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " wr_en"},    32'(ram_wr_en), 0);
    check({tag, " wr_addr"},  32'(ram_wr_addr), 0);
    check({tag, " wr_data"},  32'(ram_wr_data), 0);
    check({tag, " rd_addr"},  32'(ram_rd_addr), 0);
    check({tag, " valid"},    32'(fft_sink_valid), 0);
    check({tag, " sop"},      32'(fft_sink_sop), 0);
    check({tag, " eop"},      32'(fft_sink_eop), 0);
    check({tag, " real"},     32'(fft_sink_real), 0);
    check({tag, " frame_id"}, 32'(frame_id), 0);
    check({tag, " overflow"}, 32'(overflow), 0);
    check({tag, " busy"},     32'(busy), 0);
  endtask

  initial begin
    int bs, es, wb;
    reset = 1'b1; start = 1'b0; adc_data_valid = 1'b0; adc_data = '0;
    fft_sink_ready = 1'b0; fft_done = 1'b0;
    repeat (3) cyc();
    check_zero("reset");

    // Ramp frame with ready held high.
    reset = 1'b0; start = 1'b1; fft_sink_ready = 1'b1;
    adc_data_valid = 1'b1; adc_data = '0;
    #1;
    check("first write en", 32'(ram_wr_en), 1);
    check("first write addr", 32'(ram_wr_addr), 0);
    feed(0, N, 0);
    check("latency busy t0", 32'(busy), 0);
    check("latency valid t0", 32'(fft_sink_valid), 0);
    cyc();
    check("latency busy t1", 32'(busy), 1);
    check("latency valid t1", 32'(fft_sink_valid), 0);
    cyc();
    check("latency valid t2", 32'(fft_sink_valid), 0);
    cyc();
    check("latency valid t3", 32'(fft_sink_valid), 1);
    check("latency sop t3", 32'(fft_sink_sop), 1);
    check("latency real t3", 32'(fft_sink_real), 0);
    wait_fid(4'd1, 2000, "ramp frame_id");
    check("ramp no bubbles", eop_cyc - sop_cyc, N - 1);
    check("ramp wait_done busy", 32'(busy), 1);
    check("ramp overflow", 32'(overflow), 0);
    cmp_stream("ramp", 0, 0, N);
    fft_done = 1'b1;
    cyc();
    check("ramp done -> idle", 32'(busy), 0);

    // Two frames under random ready.
    bs = beats.size(); es = exp_q.size();
    rdy_rand = 1'b1; auto_done = 1'b1;
    feed(0, 2 * N, 'h123);
    wait_fid(4'd3, 10000, "random frame_id");
    cyc();
    cmp_stream("random", bs, es, 2 * N);
    check("random overflow", 32'(overflow), 0);
    check("random stall stability", proto_err, 0);
    rdy_rand = 1'b0; auto_done = 1'b0; fft_sink_ready = 1'b0;

    // Both banks fill with ready low; the 2049th sample is dropped.
    reset = 1'b1; cyc(); reset = 1'b0;
    wb = wr_cnt;
    for (int i = 0; i < 3 * N; i++) begin
      adc_data_valid = 1'b1;
      adc_data = W'((i + 5) & 'hFFF);
      if (i == 2 * N - 1 || i == 2 * N) begin
        #1;
        check((i == 2 * N) ? "drop wr_en" : "last fill wr_en", 32'(ram_wr_en), (i == 2 * N) ? 0 : 1);
      end
      cyc();
      if (i == 2 * N) check("overflow set", 32'(overflow), 1);
    end
    adc_data_valid = 1'b0;
    #1;
    check("overflow write count", wr_cnt - wb, 2 * N);
    check("stalled valid", 32'(fft_sink_valid), 1);
    check("stalled sop", 32'(fft_sink_sop), 1);
    check("stalled real", 32'(fft_sink_real), 5);
    check("stalled frame_id", 32'(frame_id), 0);
    reset = 1'b1; cyc(); reset = 1'b0;
    check("overflow cleared", 32'(overflow), 0);
    check("stall aborted valid", 32'(fft_sink_valid), 0);

    // fft_done ignored in IDLE, then withheld after frame 0.
    fft_sink_ready = 1'b1;
    fft_done = 1'b1;
    cyc();
    check("stray done busy", 32'(busy), 0);
    bs = beats.size(); es = exp_q.size();
    feed(0, 2 * N, 'h200);
    repeat (200) cyc();
    check("withheld frame_id", 32'(frame_id), 1);
    check("withheld busy", 32'(busy), 1);
    check("withheld valid", 32'(fft_sink_valid), 0);
    check("withheld beats", beats.size() - bs, N);
    fft_done = 1'b1;
    cyc();
    check("done -> idle", 32'(busy), 0);
    cyc();
    check("second stream busy", 32'(busy), 1);
    cyc();
    cyc();
    check("second stream valid", 32'(fft_sink_valid), 1);
    check("second stream sop", 32'(fft_sink_sop), 1);
    check("second stream real", 32'(fft_sink_real), 'h600);
    wait_fid(4'd2, 2000, "withheld frame_id 2");
    cmp_stream("withheld", bs, es, 2 * N);
    fft_done = 1'b1;
    cyc();

    // Reset at sample 500 of a fresh frame.
    feed(0, 500, 'h9A0);
    check("pre-reset wr_addr", 32'(ram_wr_addr), 500);
    reset = 1'b1;
    cyc();
    check_zero("mid-fill reset");
    reset = 1'b0;
    bs = beats.size(); es = exp_q.size();
    feed(0, N, 'h300);
    wait_fid(4'd1, 2000, "post-reset frame_id");
    check("post-reset first beat", 32'(beats[bs]), 32'({2'b10, 12'h300}));
    cmp_stream("post-reset", bs, es, N);
    fft_done = 1'b1;
    cyc();

    // start low for 100 cycles mid-frame.
    bs = beats.size(); es = exp_q.size(); wb = wr_cnt;
    feed(0, 300, 'h400);
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      adc_data_valid = 1'b1;
      adc_data = 12'hFFF;
      if (k == 50) begin
        #1;
        check("gap wr_en", 32'(ram_wr_en), 0);
      end
      cyc();
    end
    adc_data_valid = 1'b0;
    start = 1'b1;
    feed(300, N - 300, 'h400);
    wait_fid(4'd2, 2000, "gap frame_id");
    check("gap write count", wr_cnt - wb, N);
    cmp_stream("gap", bs, es, N);
    check("final stall stability", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
